// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor computing a - b (mod 2^WIDTH), LSB first,
// one bit pair per clock, with a final borrow out of the MSB.
// Optional feature macro: SERIAL_SUB_BORROW_IN_EN adds a borrow_in port that
// seeds the borrow chain, so the result becomes a - b - borrow_in.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_BORROW_IN_EN
  input  logic             borrow_in,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Partial result: the top WIDTH-1 bits gathered so far; the final bit is
  // merged in on the edge that enters DONE.
  logic [WIDTH-2:0] res;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] shifted;
  logic             seed;

`ifdef SERIAL_SUB_BORROW_IN_EN
  assign seed = borrow_in;
`else
  assign seed = 1'b0;
`endif

  // One-bit full subtractor on the current LSBs, plus the result after shifting d in.
  always_comb begin
    d       = a_sh[0] ^ b_sh[0] ^ br;
    br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    shifted = {d, res};
  end

  // Control FSM and datapath, with all outputs registered.
  // NOTE: every register here is assigned with <= so that each one samples
  // the pre-edge value of the others; a blocking = would let later
  // statements see already-updated values and break the shift chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            res   <= '0;
            br    <= seed;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          res  <= shifted[WIDTH-1:1];
          br   <= br_next;
          if (cnt == LAST) begin
            diff   <= shifted;
            borrow <= br_next;
            busy   <= 1'b0;
            done   <= 1'b1;
            cnt    <= '0;
            state  <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: scoreboard bench for serial_sub. Two instances run side by
// side: WIDTH=8 for the directed vectors and WIDTH=4 for an exhaustive sweep.
// Stimulus pushes the expected {borrow, diff} into a queue, and a monitor per
// instance pops and compares on every done pulse.
module tb_serial_sub;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start4;
  logic [7:0] a8, b8;
  logic [3:0] a4, b4;
  logic       busy8, done8, borrow8;
  logic       busy4, done4, borrow4;
  logic [7:0] diff8;
  logic [3:0] diff4;
`ifdef SERIAL_SUB_BORROW_IN_EN
  logic       bin8;
  logic       bin4;
`endif

  int total = 0;
  int bad   = 0;

  logic [8:0] q8[$];
  logic [4:0] q4[$];

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
`ifdef SERIAL_SUB_BORROW_IN_EN
    .borrow_in(bin8),
`endif
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
  );

  serial_sub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
`ifdef SERIAL_SUB_BORROW_IN_EN
    .borrow_in(bin4),
`endif
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor, WIDTH=8 instance: compare on done, check pulse width.
  logic prev_done8 = 1'b0;
  always @(negedge clk) begin
    if (done8) begin
      check("done8_single_cycle", {31'd0, prev_done8}, 32'd0);
      if (q8.size() == 0) begin
        check("done8_unexpected", 32'd1, 32'd0);
      end else begin
        logic [8:0] e;
        e = q8.pop_front();
        check("diff8", {24'd0, diff8}, {24'd0, e[7:0]});
        check("borrow8", {31'd0, borrow8}, {31'd0, e[8]});
      end
    end
    prev_done8 = done8;
  end

  // Scoreboard monitor, WIDTH=4 instance.
  logic prev_done4 = 1'b0;
  always @(negedge clk) begin
    if (done4) begin
      if (prev_done4) check("done4_single_cycle", 32'd1, 32'd0);
      if (q4.size() == 0) begin
        check("done4_unexpected", 32'd1, 32'd0);
      end else begin
        logic [4:0] e;
        e = q4.pop_front();
        check("diff4_borrow4", {27'd0, borrow4, diff4}, {27'd0, e});
      end
    end
    prev_done4 = done4;
  end

  // One WIDTH=8 operation with busy/done timing checks. glitch_at >= 0 pulses
  // start with different operands that many cycles into SHIFT.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                     input logic [7:0] ed, input logic eb, input int glitch_at);
    @(negedge clk);
    a8 = ta; b8 = tb; start8 = 1'b1;
`ifdef SERIAL_SUB_BORROW_IN_EN
    bin8 = tbin;
`else
    if (tbin) check("borrow_in_unsupported", 32'd1, 32'd0);
`endif
    q8.push_back({eb, ed});
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start8 = (i == glitch_at);
      if (i == glitch_at) begin a8 = 8'hFF; b8 = 8'h00; end
      if (!busy8 || done8) check("busy8_shift", {30'd0, busy8, done8}, 32'd2);
    end
    @(negedge clk);
    start8 = 1'b0;
    check("done8_after_width", {30'd0, busy8, done8}, 32'd1);
    @(negedge clk);
    check("done8_dropped", {30'd0, busy8, done8}, 32'd0);
  endtask

  // One WIDTH=4 operation with busy/done timing checks; expectation from
  // the arithmetic reference model.
  task automatic op4(input logic [3:0] ta, input logic [3:0] tb);
    logic [4:0] wide;
    wide = {1'b0, ta} - {1'b0, tb};
    @(negedge clk);
    a4 = ta; b4 = tb; start4 = 1'b1;
    q4.push_back({wide[4], wide[3:0]});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start4 = 1'b0;
      if (!busy4 || done4) check("busy4_shift", {30'd0, busy4, done4}, 32'd2);
    end
    @(negedge clk);
    if (busy4 || !done4) check("done4_after_width", {30'd0, busy4, done4}, 32'd1);
    @(negedge clk);
    if (busy4 || done4) check("done4_dropped", {30'd0, busy4, done4}, 32'd0);
  endtask

  initial begin
    int first_done, second_done, ndone;
    rst = 1'b1; start8 = 1'b0; start4 = 1'b0;
    a8 = '0; b8 = '0; a4 = '0; b4 = '0;
`ifdef SERIAL_SUB_BORROW_IN_EN
    bin8 = 1'b0; bin4 = 1'b0;
`endif
    // Reset dominates start.
    @(negedge clk); start8 = 1'b1; a8 = 8'h55;
    @(negedge clk); start8 = 1'b0;
    @(negedge clk);
    check("reset8_outputs", {22'd0, busy8, done8, diff8, borrow8}, 32'd0);
    check("reset4_outputs", {26'd0, busy4, done4, diff4, borrow4}, 32'd0);
    rst = 1'b0;

    // Directed WIDTH=8 vectors.
    op8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, -1);
    op8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, -1);
    op8(8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, -1);
    op8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, -1);
    // Restart attempt 3 cycles into SHIFT is ignored; operands also change.
    op8(8'h20, 8'h07, 1'b0, 8'h19, 1'b0, 2);
    repeat (3) @(negedge clk);
    check("held_after_done_diff", {24'd0, diff8}, 32'h19);

    // Reset 4 cycles into SHIFT aborts with no done pulse.
    @(negedge clk); a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("abort_outputs", {22'd0, busy8, done8, diff8, borrow8}, 32'd0);
    repeat (12) @(negedge clk);
    check("abort_no_done", {31'd0, done8}, 32'd0);
    op8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, -1);

    // Back-to-back: start held high gives one operation every WIDTH+2 cycles.
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
    q8.push_back({1'b0, 8'h0F});
    q8.push_back({1'b0, 8'h0F});
    ndone = 0; first_done = 0; second_done = 0;
    for (int i = 0; i < 40 && ndone < 2; i++) begin
      @(negedge clk);
      if (done8) begin
        ndone++;
        if (ndone == 1) first_done = i; else second_done = i;
      end else if (ndone == 1 && busy8) begin
        start8 = 1'b0;
      end
    end
    start8 = 1'b0;
    check("b2b_done_count", ndone, 32'd2);
    check("b2b_period", second_done - first_done, 32'd10);
    repeat (3) @(negedge clk);

`ifdef SERIAL_SUB_BORROW_IN_EN
    op8(8'h05, 8'h03, 1'b1, 8'h01, 1'b0, -1);
    op8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, -1);
`endif

    // Exhaustive WIDTH=4 sweep.
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        op4(4'(x), 4'(y));

    repeat (4) @(negedge clk);
    check("q8_drained", q8.size(), 32'd0);
    check("q4_drained", q4.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so a stuck design still ends the run.
  initial begin
    #400000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
